// File: rtl/ser_arbiter.sv
// Round-robin arbiter that shares one byte serializer among NREQ requesters.
// It grants one packet, loads the serializer, shifts the packet out under tx_ready, then pulses done.
module ser_arbiter #(
    parameter int NREQ   = 4,
    parameter int IDX_W  = 2,
    parameter int DATA_W = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ*4-1:0]        req_bytecount,
    output logic [NREQ-1:0]          req_done,
    output logic [DATA_W-1:0]        ser_din,
    output logic [3:0]               ser_bytecount,
    output logic                     ser_begin,
    output logic                     ser_shift,
    input  logic [7:0]               ser_byte,
    input  logic                     ser_empty,
    input  logic                     tx_ready,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    output logic                     tx_last,
    output logic [IDX_W-1:0]         tx_src,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    src_q;
    logic [4:0]          cnt_q;
    logic [DATA_W-1:0]   din_q;
    logic [3:0]          bc_q;
    logic                begin_q;
    logic                valid_q;
    logic                last_q;

    logic                grant_vld;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    ptr_d;
    logic [DATA_W-1:0]   grant_data;
    logic [3:0]          grant_bc;
    logic                shift;

    // First set request at or after the pointer, wrapping at NREQ.
    always_comb begin
        int unsigned k;
        grant_vld = 1'b0;
        grant_idx = '0;
        k         = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = (32'(ptr_q) + i) % NREQ;
            if (!grant_vld && req[IDX_W'(k)]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end

    assign grant_data = req_data[32'(grant_idx)*DATA_W +: DATA_W];
    assign grant_bc   = req_bytecount[32'(grant_idx)*4 +: 4];
    assign ptr_d      = IDX_W'((32'(grant_idx) + 1) % NREQ);

    assign shift = (state_q == SEND) && tx_ready && !reset;

    always_comb begin
        req_done = '0;
        if (shift && cnt_q == 5'd1) begin
            req_done[src_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            cnt_q   <= '0;
            din_q   <= '0;
            bc_q    <= '0;
            begin_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            begin_q <= 1'b0;
            valid_q <= shift;
            last_q  <= shift && (cnt_q == 5'd1);
            case (state_q)
                IDLE: begin
                    if (grant_vld && ser_empty) begin
                        src_q   <= grant_idx;
                        din_q   <= grant_data;
                        bc_q    <= grant_bc;
                        cnt_q   <= {1'b0, grant_bc} + 5'd1;
                        ptr_q   <= ptr_d;
                        begin_q <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: state_q <= SEND;
                SEND: begin
                    if (shift) begin
                        cnt_q <= cnt_q - 5'd1;
                        if (cnt_q == 5'd1) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ser_din       = din_q;
    assign ser_bytecount = bc_q;
    assign ser_begin     = begin_q;
    assign ser_shift     = shift;
    assign tx_valid      = valid_q;
    assign tx_last       = last_q;
    assign tx_data       = ser_byte;
    assign tx_src        = src_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: doc/ser_arbiter.md
Name: ser_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one byte serializer among NREQ requesters.
- Each requester offers a packet of up to 16 bytes. The controller:
  - grants one requester;
  - loads the serializer with that packet;
  - paces shifting from a downstream ready signal;
  - forwards each byte with source tag and last flag;
  - acknowledges the requester with a done pulse.
- Sits between CPU-side message sources (debug, status, reply) and the byte link (UART tx path).

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDX_W, 2, width of requester index; must equal clog2(NREQ).
- DATA_W, 256, per-requester payload width, byte 0 in bits [7:0].

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req  in  NREQ  per-requester request level.
- req_data  in  NREQ*DATA_W  packed payloads; requester i at [i*DATA_W +: DATA_W].
- req_bytecount  in  NREQ*4  packed byte counts; number of bytes sent = field+1.
- req_done  out  NREQ  one-cycle done pulse to the granted requester.
- ser_din  out  DATA_W  payload to serializer (registered).
- ser_bytecount  out  4  byte count to serializer (registered).
- ser_begin  out  1  serializer load strobe.
- ser_shift  out  1  serializer shift enable.
- ser_byte  in  8  serializer output byte; updates on the edge ending a ser_shift cycle.
- ser_empty  in  1  serializer empty flag.
- tx_ready  in  1  downstream can accept a byte on the next cycle.
- tx_valid  out  1  tx_data valid this cycle.
- tx_data  out  8  byte out; combinational passthrough of ser_byte.
- tx_last  out  1  tx_data is the final byte of the packet.
- tx_src  out  IDX_W  index of the requester that owns the current packet.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset:
  - state=IDLE.
  - req_done, ser_begin, ser_shift, tx_valid, tx_last, busy all 0.
  - ser_din=0, ser_bytecount=0, tx_src=0.
  - Round-robin pointer set so requester 0 has top priority on the first arbitration.
  - The serializer shares this reset.
  - Reset mid-packet aborts the packet: no req_done, no further tx_valid.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - If any req bit is set and ser_empty=1, grant the first set bit searching upward (with wrap) from the index after the last winner.
  - Latch winner into tx_src; register its payload into ser_din and its bytecount into ser_bytecount.
  - Set remaining counter cnt = bytecount+1 (5 bits); advance pointer to winner+1 mod NREQ; go to LOAD.
  - No request -> stay in IDLE.
- LOAD: ser_begin=1 for exactly this cycle; go to SEND.
- SEND:
  - ser_shift = tx_ready, combinational.
  - Each cycle with ser_shift=1: cnt decrements.
  - If cnt==1 during a shift: req_done[tx_src]=1 that cycle; go to DONE.
  - tx_ready=0 -> hold state; no shift.
- DONE: no shift; go to IDLE next cycle.
- tx_valid: register of ser_shift (one cycle later).
- tx_last: register of (ser_shift and cnt==1).
- Downstream must accept every tx_valid cycle; no backpressure on tx_valid itself.
- Latency:
  - Arbitration cycle T, ser_begin at T+1, first shift at T+2, first tx_valid at T+3.
  - With tx_ready held high, an n-byte packet occupies n+3 cycles; back-to-back packets have a 3-cycle gap between the last tx_valid and the next first tx_valid.
- Requester contract:
  - Hold req, req_data and req_bytecount stable from assertion until req_done.
  - Drop req no later than the cycle after req_done.
  - Deassertion after grant is ignored; the packet completes.
- Simultaneous requests: resolved only by rotating priority. A requester that re-requests immediately cannot be granted twice in a row while another requester is waiting.
- bytecount=15 -> 16 bytes sent. Payload bits above byte 15 are ignored.
- busy=1 in LOAD, SEND and DONE.

Test Plan:
- Reset, then req=0001, bytecount=2, data=0x..332211, tx_ready=1 -> ser_begin at T+1; tx_valid on T+3..T+5 with tx_data 0x11,0x22,0x33; tx_last only at T+5; req_done[0] at T+4; tx_src=0.
- req=1111 held continuously, each bytecount=0 -> grants in order 0,1,2,3,0; each packet has 1 tx_valid, tx_valid pulses 4 cycles apart.
- tx_ready toggled 1,0,0,1 during a 3-byte packet -> shifts only on ready cycles; bytes are in order with no duplicates or drops; cnt holds while ready=0.
- bytecount=15 with data bytes 0x00..0x0F -> 16 tx_valid cycles, values 0x00..0x0F; tx_last on byte 0x0F.
- Reset asserted in SEND after 2 of 5 bytes -> next cycle busy=0 and tx_valid=0; no req_done; a fresh request starts cleanly with requester 0 priority.
- req[2] dropped one cycle after grant -> packet still completes and req_done[2] pulses; requester 3 (also requesting) is granted next.
